// File: rtl/fantasticfft_pkg.sv
// Shared types for the FFT8 frame sequencer slice.
//   fixed_t      : Q8.8 two's complement sample, index range [7:-8].
//   complex_t    : packed {re, im} pair of fixed_t.
//   seq_state_e  : sequencer FSM states.
//   FFT_N, IDX_W : frame length and the width of a bin/sample index.
package fantasticfft_pkg;

    localparam int FFT_N = 8;
    localparam int IDX_W = $clog2(FFT_N);

    typedef logic [7:-8] fixed_t;

    typedef struct packed {
        fixed_t re;
        fixed_t im;
    } complex_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fantasticfft_frame_buffer.sv
// FFT_N-entry register array holding one frame.
// Ports:
//   clk       : rising-edge clock
//   clr       : synchronous clear of every entry (highest priority)
//   wr_en     : indexed write of wr_data at wr_idx
//   ld_en     : parallel write of all entries from ld_data (beats wr_en)
//   rd_idx    : indexed read address, rd_data is combinational
//   par_data  : parallel read of all entries
module fantasticfft_frame_buffer
    import fantasticfft_pkg::*;
#(
    parameter type elem_t = fixed_t
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  elem_t            wr_data,
    input  logic             ld_en,
    input  elem_t            ld_data [0:FFT_N-1],
    input  logic [IDX_W-1:0] rd_idx,
    output elem_t            rd_data,
    output elem_t            par_data [0:FFT_N-1]
);

    elem_t mem [0:FFT_N-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < FFT_N; i++) mem[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < FFT_N; i++) mem[i] <= ld_data[i];
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    always_comb begin
        for (int i = 0; i < FFT_N; i++) par_data[i] = mem[i];
    end

endmodule

// File: rtl/fantasticfft_fft8_sequencer.sv
// Frame sequencer for the FFT8 datapath: gathers 8 serial real samples,
// launches the core with a one-cycle fft_is_valid strobe, waits (bounded)
// for fft_result_valid and then streams the 8 complex bins out serially.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : sample input stream
//   fft_x, fft_is_valid          : drive side of the FFT8 core
//   fft_y, fft_yi, fft_result_valid : result side of the FFT8 core
//   out_valid/out_ready, out_re, out_im, out_index, out_last : bin stream
//   busy, timeout_pulse, timeout_sticky, frame_count : status
//   dbg_state                    : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; once out_valid is raised it stays
// high with out_re/out_im/out_index/out_last unchanged until the transfer.
module fantasticfft_fft8_sequencer
    import fantasticfft_pkg::*;
#(
    parameter int INT_BITS       = 8,
    parameter int FRAC_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS-1:-FRAC_BITS]  in_data,
    output logic [INT_BITS-1:-FRAC_BITS]  fft_x [0:FFT_N-1],
    output logic                          fft_is_valid,
    input  logic [INT_BITS-1:-FRAC_BITS]  fft_y [0:FFT_N-1],
    input  logic [INT_BITS-1:-FRAC_BITS]  fft_yi [0:FFT_N-1],
    input  logic                          fft_result_valid,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INT_BITS-1:-FRAC_BITS]  out_re,
    output logic [INT_BITS-1:-FRAC_BITS]  out_im,
    output logic [IDX_W-1:0]              out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          timeout_pulse,
    output logic                          timeout_sticky,
    output logic [15:0]                   frame_count,
    output seq_state_e                    dbg_state
);

    typedef logic [INT_BITS-1:-FRAC_BITS] sample_t;
    typedef struct packed {
        sample_t re;
        sample_t im;
    } bin_t;

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic             sticky_q;
    logic [15:0]      frame_cnt_q;

    logic accept, launch, capture, timeout, handshake;

    sample_t smp_par [0:FFT_N-1];
    sample_t smp_ld_unused [0:FFT_N-1];
    sample_t smp_rd_unused;
    bin_t    res_in [0:FFT_N-1];
    bin_t    res_par_unused [0:FFT_N-1];
    bin_t    res_rd;

    // in_ready is forced low while rst is high so no sample is taken in the
    // reset cycle regardless of which state is being left.
    assign in_ready = (state_q == LOAD) && !rst;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        launch    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            LOAD: begin
                accept = in_valid && in_ready;
                if (accept && wr_idx_q == LAST_IDX) state_d = LAUNCH;
            end
            LAUNCH: begin
                launch  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle beats the timeout.
                if (fft_result_valid) begin
                    capture = 1'b1;
                    state_d = UNLOAD;
                end else if (wait_cnt_q == WCW'(TIMEOUT_CYCLES)) begin
                    timeout = 1'b1;
                    state_d = LOAD;
                end
            end
            UNLOAD: begin
                handshake = out_ready;
                if (out_ready && rd_idx_q == LAST_IDX) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            wait_cnt_q  <= '0;
            sticky_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            // wr_idx wraps back to 0 after the 8th sample on its own.
            if (timeout)     wr_idx_q <= '0;
            else if (accept) wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (launch) begin
                wait_cnt_q <= WCW'(1);
            end else if (state_q == WAIT && !capture && !timeout) begin
                wait_cnt_q <= wait_cnt_q + WCW'(1);
            end
            if (timeout) sticky_q <= 1'b1;
            if (handshake) begin
                rd_idx_q <= rd_idx_q + IDX_W'(1);
                if (rd_idx_q == LAST_IDX) frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FFT_N; i++) begin
            smp_ld_unused[i] = '0;
            res_in[i]        = '{re: fft_y[i], im: fft_yi[i]};
        end
    end

    fantasticfft_frame_buffer #(.elem_t(sample_t)) u_sample_buf (
        .clk      (clk),
        .clr      (rst),
        .wr_en    (accept),
        .wr_idx   (wr_idx_q),
        .wr_data  (in_data),
        .ld_en    (1'b0),
        .ld_data  (smp_ld_unused),
        .rd_idx   ('0),
        .rd_data  (smp_rd_unused),
        .par_data (smp_par)
    );

    fantasticfft_frame_buffer #(.elem_t(bin_t)) u_result_buf (
        .clk      (clk),
        .clr      (rst),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .ld_en    (capture),
        .ld_data  (res_in),
        .rd_idx   (rd_idx_q),
        .rd_data  (res_rd),
        .par_data (res_par_unused)
    );

    // The core only sees the frame during the launch cycle; zero otherwise.
    always_comb begin
        for (int i = 0; i < FFT_N; i++) fft_x[i] = launch ? smp_par[i] : '0;
    end

    assign fft_is_valid   = launch;
    assign out_valid      = (state_q == UNLOAD);
    assign out_re         = out_valid ? res_rd.re : '0;
    assign out_im         = out_valid ? res_rd.im : '0;
    assign out_index      = out_valid ? rd_idx_q : '0;
    assign out_last       = out_valid && (rd_idx_q == LAST_IDX);
    assign busy           = (state_q != LOAD);
    assign timeout_pulse  = timeout;
    assign timeout_sticky = sticky_q;
    assign frame_count    = frame_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fantasticfft_fft8_sequencer.sv
// Testbench for fantasticfft_fft8_sequencer with a behavioural FFT8 core
// model and a queue-based scoreboard on the output bin stream.
module tb_fantasticfft_fft8_sequencer;
    import fantasticfft_pkg::*;

    localparam int W = 36; // {index[2:0], last, re[15:0], im[15:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:-8] in_data = '0;
    logic [7:-8] fft_x [0:7];
    logic        fft_is_valid;
    logic [7:-8] fft_y [0:7];
    logic [7:-8] fft_yi [0:7];
    logic        fft_result_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:-8] out_re, out_im;
    logic [2:0]  out_index;
    logic        out_last, busy, timeout_pulse, timeout_sticky;
    logic [15:0] frame_count;
    seq_state_e  dbg_state;

    fantasticfft_fft8_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .fft_x(fft_x), .fft_is_valid(fft_is_valid),
        .fft_y(fft_y), .fft_yi(fft_yi), .fft_result_valid(fft_result_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last),
        .busy(busy), .timeout_pulse(timeout_pulse), .timeout_sticky(timeout_sticky),
        .frame_count(frame_count), .dbg_state(dbg_state)
    );

    // ---------------- hand-computed vectors ----------------
    logic [15:0] ramp_x  [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400,
                                 16'h0500, 16'h0600, 16'h0700, 16'h0800};
    logic [15:0] ramp_re [8] = '{16'h2400, 16'hFC00, 16'hFC00, 16'hFC00,
                                 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    logic [15:0] ramp_im [8] = '{16'h0000, 16'h09A8, 16'h0400, 16'h01A8,
                                 16'h0000, 16'hFE58, 16'hFC00, 16'hF658};
    // Delayed impulse x[1]=1.0: X_k = exp(-j*2*pi*k/8), 0.7071 -> 0x00B5.
    logic [15:0] imp_x   [8] = '{16'h0000, 16'h0100, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] imp_re  [8] = '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4B,
                                 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5};
    logic [15:0] imp_im  [8] = '{16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B,
                                 16'h0000, 16'h00B5, 16'h0100, 16'h00B5};

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_x [8];
    int total = 0;
    int bad = 0;
    int launch_cnt = 0, launch_cyc = 0, acc_cyc = 0;
    int tp_cnt = 0, tp_cyc = 0, ov_cnt = 0, pop_cnt = 0;
    int res_cyc = 0;
    bit first_pending = 0;
    bit held_v = 0;
    logic [W-1:0] held, cur, e;
    logic [15:0]  x_or;

    // model controls
    int model_mode = 0;   // 0 respond, 1 never respond
    int model_lat  = 3;
    bit spur_unload = 0;
    int rdy_mode = 0;     // 0 high, 1 random, 2 low

    function automatic logic [W-1:0] pack(input logic [2:0] idx, input logic last,
                                          input logic [15:0] re, input logic [15:0] im);
        return {idx, last, re, im};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            held_v = 0;
        end else begin
            if (in_valid && in_ready) acc_cyc = cyc;
            if (fft_is_valid) begin
                launch_cnt++;
                launch_cyc = cyc;
                chk("launch_latency", W'(cyc), W'(acc_cyc + 1));
                for (int i = 0; i < 8; i++) chk("fft_x", W'(fft_x[i]), W'(exp_x[i]));
            end else begin
                x_or = '0;
                for (int i = 0; i < 8; i++) x_or = x_or | fft_x[i];
                chk("fft_x_idle", W'(x_or), '0);
            end
            if (timeout_pulse) begin
                tp_cnt++;
                tp_cyc = cyc;
            end
            if (out_valid) begin
                ov_cnt++;
                cur = pack(out_index, out_last, out_re, out_im);
                if (first_pending) begin
                    chk("result_to_out_latency", W'(cyc), W'(res_cyc + 1));
                    first_pending = 0;
                end
                if (held_v) chk("stall_hold", cur, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_bin: got %0h expected none (cycle %0d)", cur, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bin", cur, e);
                    end
                    pop_cnt++;
                end
                held_v = !out_ready;
                held   = cur;
            end else begin
                held_v = 0;
            end
        end
    end

    // ---------------- behavioural FFT8 core ----------------
    initial begin : fft_model
        logic [15:0] xs [8];
        logic [15:0] mre [8];
        logic [15:0] mim [8];
        real ar, ai, xr, ang;
        int  ri;
        for (int i = 0; i < 8; i++) begin
            fft_y[i]  = '0;
            fft_yi[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (fft_is_valid && !rst) begin
                for (int i = 0; i < 8; i++) xs[i] = fft_x[i];
                for (int k = 0; k < 8; k++) begin
                    ar = 0.0;
                    ai = 0.0;
                    for (int n = 0; n < 8; n++) begin
                        xr  = $itor($signed(xs[n]));
                        ang = 2.0 * 3.14159265358979 * k * n / 8.0;
                        ar  = ar + xr * $cos(ang);
                        ai  = ai - xr * $sin(ang);
                    end
                    ri = (ar >= 0.0) ? $rtoi(ar + 0.5) : -$rtoi(-ar + 0.5);
                    mre[k] = 16'(ri);
                    ri = (ai >= 0.0) ? $rtoi(ai + 0.5) : -$rtoi(-ai + 0.5);
                    mim[k] = 16'(ri);
                end
                if (model_mode == 0) begin
                    repeat (model_lat) @(posedge clk);
                    #1;
                    for (int i = 0; i < 8; i++) begin
                        fft_y[i]  = mre[i];
                        fft_yi[i] = mim[i];
                    end
                    fft_result_valid = 1'b1;
                    res_cyc = cyc;
                    first_pending = 1;
                    @(posedge clk);
                    #1;
                    fft_result_valid = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        fft_y[i]  = '0;
                        fft_yi[i] = '0;
                    end
                    if (spur_unload) begin
                        repeat (2) @(posedge clk);
                        #1;
                        for (int i = 0; i < 8; i++) begin
                            fft_y[i]  = 16'h7777;
                            fft_yi[i] = 16'h1234;
                        end
                        fft_result_valid = 1'b1;
                        repeat (2) @(posedge clk);
                        #1;
                        fft_result_valid = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_fft_is_valid", W'(fft_is_valid), '0);
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_re", W'(out_re), '0);
        chk("rst_out_im", W'(out_im), '0);
        chk("rst_out_index", W'(out_index), '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_timeout_pulse", W'(timeout_pulse), '0);
        chk("rst_timeout_sticky", W'(timeout_sticky), '0);
        chk("rst_frame_count", W'(frame_count), '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("in_ready_during_reset", W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
    endtask

    task automatic send_frame(input int sel, input int gap_max, input bit expect_out);
        int guard;
        bit ok;
        for (int i = 0; i < 8; i++) exp_x[i] = (sel == 0) ? ramp_x[i] : imp_x[i];
        if (expect_out) begin
            for (int k = 0; k < 8; k++) begin
                if (sel == 0) exp_q.push_back(pack(3'(k), k == 7, ramp_re[k], ramp_im[k]));
                else          exp_q.push_back(pack(3'(k), k == 7, imp_re[k], imp_im[k]));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = exp_x[i];
            guard = 0;
            ok = 0;
            while (!ok && guard < 300) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL sample_accept_timeout: got no in_ready expected in_ready (sample %0d)", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        bit done = 0;
        while (!done && guard < 400) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) done = 1;
            guard++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL frame_done_timeout: got %0d bins left expected 0", exp_q.size());
        end
    endtask

    // ---------------- test sequence ----------------
    int lc0, tp0, ov0, pc0, guard;

    initial begin : main
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_during_reset", W'(in_ready), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // F1: ramp, full speed, latency 3
        lc0 = launch_cnt;
        send_frame(0, 0, 1);
        wait_done();
        chk("f1_load_resume", W'(cyc), W'(res_cyc + 9));
        chk("f1_launches", W'(launch_cnt - lc0), W'(1));
        chk("f1_frame_count", W'(frame_count), W'(1));

        // F2: impulse, input gaps, random ready, spurious results in LOAD/UNLOAD
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            fft_y[i]  = 16'h5A5A;
            fft_yi[i] = 16'hA5A5;
        end
        fft_result_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fft_result_valid = 1'b0;
        chk("f2_spurious_load_busy", W'(busy), '0);
        rdy_mode = 1;
        spur_unload = 1;
        lc0 = launch_cnt;
        send_frame(1, 3, 1);
        wait_done();
        spur_unload = 0;
        rdy_mode = 0;
        chk("f2_launches", W'(launch_cnt - lc0), W'(1));
        chk("f2_frame_count", W'(frame_count), W'(2));

        // F3: core never answers -> timeout
        model_mode = 1;
        tp0 = tp_cnt;
        ov0 = ov_cnt;
        send_frame(0, 0, 0);
        guard = 0;
        while (tp_cnt == tp0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("f3_timeout_offset", W'(tp_cyc - launch_cyc), W'(10));
        @(negedge clk);
        chk("f3_timeout_pulses", W'(tp_cnt - tp0), W'(1));
        chk("f3_sticky", W'(timeout_sticky), W'(1));
        chk("f3_load_resume", W'(in_ready), W'(1));
        chk("f3_no_out_valid", W'(ov_cnt - ov0), '0);
        chk("f3_frame_count", W'(frame_count), W'(2));

        // F4: normal frame after the timeout
        model_mode = 0;
        send_frame(0, 0, 1);
        wait_done();
        chk("f4_frame_count", W'(frame_count), W'(3));
        chk("f4_sticky_kept", W'(timeout_sticky), W'(1));

        // F5: result exactly when wait_cnt reaches the timeout
        model_lat = 10;
        tp0 = tp_cnt;
        send_frame(1, 0, 1);
        wait_done();
        chk("f5_no_timeout", W'(tp_cnt - tp0), '0);
        chk("f5_frame_count", W'(frame_count), W'(4));

        // F6: reset while waiting, then a clean frame
        model_lat = 8;
        send_frame(0, 0, 0);
        repeat (4) @(posedge clk);
        do_reset();
        model_lat = 3;
        send_frame(1, 0, 1);
        wait_done();
        chk("f7_frame_count", W'(frame_count), W'(1));

        // F8: reset during UNLOAD after bin 3, then a clean frame
        pc0 = pop_cnt;
        send_frame(0, 0, 1);
        guard = 0;
        while (pop_cnt - pc0 < 4 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("f8_bins_before_reset", W'(pop_cnt - pc0), W'(4));
        #1;
        rdy_mode = 2;
        out_ready = 1'b0;
        do_reset();
        rdy_mode = 0;
        send_frame(0, 0, 1);
        wait_done();
        chk("f9_frame_count", W'(frame_count), W'(1));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        bad++;
        $display("FAIL watchdog: got no completion expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
